// File: rtl/mem_access_unit_if.sv
// Request/response bundle between a requester (master) and mem_access_unit (slave).
// Handshake: a request is accepted only at an edge where busy is low and exactly one of
// read_req/write_req is high; completion is the single-cycle mem_ready pulse, and
// requests presented while busy are dropped, so the master holds or re-issues them.
interface mem_access_unit_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              read_req;
  logic              write_req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_ready;
  logic              busy;
  logic              err;

  modport master (
    output read_req, write_req, addr, wdata,
    input  rdata, mem_ready, busy, err
  );

  modport slave (
    input  read_req, write_req, addr, wdata,
    output rdata, mem_ready, busy, err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-word memory stage feeding the MDR: a 2**ADDR_W-word RAM behind a
// three-state IDLE/ACCESS/DONE controller with WAIT_CYCLES stall cycles per access.
module mem_access_unit #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                clr,
  mem_access_unit_if.slave    bus,
  output logic [1:0]          dbg_state
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.read_req ^ bus.write_req) begin
          op_wr_d = bus.write_req;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = WAIT_LD;
          state_d = ST_ACCESS;
        end else if (bus.read_req && bus.write_req) begin
          err_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Commit point: the memory or rdata changes only on this edge.
          if (op_wr_q) mem_we = 1'b1;
          else         rdata_d = mem[addr_q];
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; a reset before the commit edge leaves mem_we low.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

  assign bus.rdata     = rdata_q;
  assign bus.mem_ready = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.err       = err_q;
  assign dbg_state     = state_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage that sits directly upstream of the control unit's MDR input.
- Accepts single-word read/write requests carrying a MAR address and MDR write data.
- Models a 512-word synchronous RAM with a configurable number of wait states.
- Returns read data on rdata, which drives the datapath's MDRMDataIn, and signals completion with a one-cycle mem_ready pulse.

Parameters:
- ADDR_W, 9, address width; memory depth is 2**ADDR_W words.
- DATA_W, 32, word width.
- WAIT_CYCLES, 2, extra stall cycles per access; legal range is 0 to 15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  reset, asynchronous, active-low.
- read_req  input  1  read request, sampled only in IDLE.
- write_req  input  1  write request, sampled only in IDLE.
- addr  input  ADDR_W  word address from MAR.
- wdata  input  DATA_W  write data from MDR.
- rdata  output  DATA_W  read data to MDR (MDRMDataIn).
- mem_ready  output  1  one-cycle completion pulse.
- busy  output  1  high while an access is in flight (ACCESS or DONE).
- err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (clr=0, asynchronous):
  - State goes to IDLE.
  - rdata=0, mem_ready=0, busy=0, err=0, wait counter=0, latched op/addr/data cleared.
  - RAM contents are not cleared.
- States are IDLE, ACCESS and DONE.
- IDLE:
  - If exactly one of read_req/write_req is high at an edge: latch op, addr and wdata; load counter with WAIT_CYCLES; go to ACCESS; busy rises.
  - If both are high: no access, err=1 for exactly one cycle, stay in IDLE.
  - If neither is high: stay in IDLE.
- ACCESS:
  - Counter nonzero: decrement and stay.
  - Counter zero, read: rdata <= mem[latched addr].
  - Counter zero, write: mem[latched addr] <= latched wdata; rdata is unchanged.
  - On counter zero, set mem_ready=1 and go to DONE.
- DONE:
  - mem_ready is high for this single cycle.
  - On the next edge, mem_ready=0, busy=0, go to IDLE.
- Latency:
  - Request sampled at edge E. The access commits and mem_ready rises at edge E+WAIT_CYCLES+1. IDLE is re-entered at edge E+WAIT_CYCLES+2.
  - With WAIT_CYCLES=0, mem_ready rises at E+1. ACCESS always lasts at least one cycle.
- Requests seen in ACCESS or DONE are ignored, with no err and no queueing. The requester must hold its request or re-issue it once busy falls.
- Changes to addr/wdata after the sampling edge have no effect on the access in flight.
- rdata holds the last read value until the next read commits or a reset occurs. Writes never disturb rdata.
- Addresses 0 to 2**ADDR_W-1 are all valid; there is no out-of-range case and no wrap within an access.
- Reset asserted mid-access:
  - Return to IDLE immediately.
  - A write whose commit edge has not yet occurred is discarded; the memory location keeps its old value.
  - A pending read leaves rdata at 0.
- Read of a never-written location returns X in simulation; the bench must not check it.

Test Plan:
- WAIT_CYCLES=2: write_req=1, addr=0x005, wdata=0xDEADBEEF at edge 0 → mem_ready pulses at edge 3, busy high for edges 1–3. Then read_req, addr=0x005 → rdata=0xDEADBEEF with mem_ready 3 cycles after sampling, and rdata stable afterwards.
- read_req=1 and write_req=1 together in IDLE → err high exactly one cycle, busy stays 0, no mem_ready. A subsequent read of that address returns the prior value.
- Start a write of 0x12345678 to 0x010 (old value 0x0000AAAA); assert clr=0 one cycle after sampling → all outputs 0 at once. After release, reading 0x010 returns 0x0000AAAA.
- During busy, toggle read_req and change addr to 0x0FF → the in-flight access completes on the originally latched address, and no extra mem_ready or err is produced.
- WAIT_CYCLES=0: write then read 0x1FF (top address) with 0xCAFEF00D → each mem_ready arrives 1 cycle after sampling, and rdata=0xCAFEF00D.
- Back-to-back reads of 0x001 (value 0x11) and 0x002 (value 0x22), each issued as soon as busy falls → rdata changes 0x11 to 0x22 only at the second mem_ready edge.
